// File: rtl/rv32_mc_core.sv
// Minimal multicycle RV32I core (AUIPC, LUI, OP-IMM, OP, LW, SW) with unified word memory.
// Define RETIRE_TRACE_EN to print a line for every register write-back and store.

package rv32_mc_pkg;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                           ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_LUI  = 7'b0110111,
                           OP_IMM   = 7'b0010011, OP_REG  = 7'b0110011,
                           OP_LOAD  = 7'b0000011, OP_STORE = 7'b0100011;
    localparam logic [1:0] SRC_A = 2'd0, SRC_PC_OLD = 2'd1, SRC_ZERO = 2'd2;
endpackage

module rv32_mc_memory #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic [29:0] word_addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]   M [0:MEM_WORDS-1];
    logic [AW-1:0] idx;

    // Word addresses past the end wrap around the array.
    assign idx   = AW'(word_addr % 30'(MEM_WORDS));
    assign rdata = M[idx];

    always_ff @(posedge clk)
        if (we) M[idx] <= wdata;
endmodule

module rv32_mc_regfile (
    input  logic        clk,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] RFMem [0:31];

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : RFMem[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : RFMem[ra2];

    always_ff @(posedge clk)
        if (we) RFMem[wa] <= (wa == 5'd0) ? 32'd0 : wd;
endmodule

module rv32_mc_decode
    import rv32_mc_pkg::*;
(
    input  logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic [31:0] imm_ext
);
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign funct7b5 = instr[30];

    always_comb begin
        imm_ext = {{20{instr[31]}}, instr[31:20]};
        if (opcode == OP_LUI || opcode == OP_AUIPC)
            imm_ext = {instr[31:12], 12'b0};
        else if (opcode == OP_STORE)
            imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    end
endmodule

module rv32_mc_control_fsm
    import rv32_mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic       ir_write,
    output logic       ab_write,
    output logic       alu_out_write,
    output logic       data_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       wb_sel,
    output logic [1:0] src_a,
    output logic       src_b,
    output logic [3:0] alu_control
);
    localparam logic [5:0] FETCH = 6'd0, DECODE = 6'd1, AUIPC = 6'd2, LUI = 6'd3,
                           EXECUTEI = 6'd4, EXECUTER = 6'd5, MEMADR = 6'd6,
                           MEMREAD = 6'd7, MEMWB = 6'd8, MEMWRITE = 6'd9, ALUWB = 6'd10;

    logic [5:0] current_state, next_state;

    function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_fn = sub ? ALU_SUB : ALU_ADD;
            3'b100:  alu_fn = ALU_XOR;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            3'b010:  alu_fn = ALU_SLT;
            default: alu_fn = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset)
        if (reset) current_state <= FETCH;
        else       current_state <= next_state;

    always_comb begin
        next_state    = FETCH;
        ir_write      = 1'b0;
        ab_write      = 1'b0;
        alu_out_write = 1'b0;
        data_write    = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = 1'b0;
        src_a         = SRC_A;
        src_b         = 1'b0;
        alu_control   = ALU_ADD;
        case (current_state)
            FETCH: begin
                ir_write   = 1'b1;
                next_state = DECODE;
            end
            DECODE: begin
                ab_write = 1'b1;
                case (opcode)
                    OP_AUIPC:          next_state = AUIPC;
                    OP_LUI:            next_state = LUI;
                    OP_IMM:            next_state = EXECUTEI;
                    OP_REG:            next_state = EXECUTER;
                    OP_LOAD, OP_STORE: next_state = MEMADR;
                    default:           next_state = FETCH;
                endcase
            end
            AUIPC: begin
                src_a = SRC_PC_OLD; src_b = 1'b1; alu_out_write = 1'b1; next_state = ALUWB;
            end
            LUI: begin
                src_a = SRC_ZERO; src_b = 1'b1; alu_out_write = 1'b1; next_state = ALUWB;
            end
            EXECUTEI: begin
                src_b = 1'b1; alu_control = alu_fn(funct3, 1'b0);
                alu_out_write = 1'b1; next_state = ALUWB;
            end
            EXECUTER: begin
                alu_control = alu_fn(funct3, funct7b5);
                alu_out_write = 1'b1; next_state = ALUWB;
            end
            MEMADR: begin
                src_b = 1'b1; alu_out_write = 1'b1;
                next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD:  begin data_write = 1'b1; next_state = MEMWB; end
            MEMWB:    begin reg_write = 1'b1; wb_sel = 1'b1; next_state = FETCH; end
            MEMWRITE: begin mem_write = 1'b1; next_state = FETCH; end
            ALUWB:    begin reg_write = 1'b1; next_state = FETCH; end
            default:  next_state = FETCH;
        endcase
    end
endmodule

module rv32_mc_core
    import rv32_mc_pkg::*;
#(
    parameter int          MEM_WORDS = 256,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input logic clk,
    input logic reset
);
    logic [31:0] pc, pc_old, instr, a_reg, b_reg, alu_out, data_reg;
    logic [31:0] alu_input_a, alu_input_b, alu_result, imm_ext;
    logic [31:0] rd1, rd2, mem_rdata, wb_data;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [3:0]  __tmp_ALUControl;
    logic        ir_write, ab_write, alu_out_write, data_write, mem_write, reg_write, wb_sel, src_b;
    logic [1:0]  src_a;

    // One memory port: instruction fetch in FETCH, data access otherwise.
    rv32_mc_memory #(.MEM_WORDS(MEM_WORDS)) memory (
        .clk(clk), .word_addr(ir_write ? pc[31:2] : alu_out[31:2]),
        .we(mem_write), .wdata(b_reg), .rdata(mem_rdata));

    rv32_mc_decode instruction_decode (
        .instr(instr), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7b5(funct7b5), .imm_ext(imm_ext));

    rv32_mc_regfile RegFile (
        .clk(clk), .ra1(rs1), .ra2(rs2), .wa(rd), .we(reg_write), .wd(wb_data),
        .rd1(rd1), .rd2(rd2));

    rv32_mc_control_fsm control_fsm (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .ir_write(ir_write), .ab_write(ab_write), .alu_out_write(alu_out_write),
        .data_write(data_write), .mem_write(mem_write), .reg_write(reg_write),
        .wb_sel(wb_sel), .src_a(src_a), .src_b(src_b), .alu_control(__tmp_ALUControl));

    always_comb begin
        case (src_a)
            SRC_PC_OLD: alu_input_a = pc_old;
            SRC_ZERO:   alu_input_a = 32'd0;
            default:    alu_input_a = a_reg;
        endcase
        alu_input_b = src_b ? imm_ext : b_reg;
    end

    always_comb begin
        case (__tmp_ALUControl)
            ALU_SUB: alu_result = alu_input_a - alu_input_b;
            ALU_AND: alu_result = alu_input_a & alu_input_b;
            ALU_OR:  alu_result = alu_input_a | alu_input_b;
            ALU_XOR: alu_result = alu_input_a ^ alu_input_b;
            ALU_SLT: alu_result = {31'd0, $signed(alu_input_a) < $signed(alu_input_b)};
            default: alu_result = alu_input_a + alu_input_b;
        endcase
    end

    assign wb_data = wb_sel ? data_reg : alu_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            pc_old   <= 32'd0;
            instr    <= 32'd0;
            a_reg    <= 32'd0;
            b_reg    <= 32'd0;
            alu_out  <= 32'd0;
            data_reg <= 32'd0;
        end else begin
            if (ir_write) begin
                instr  <= mem_rdata;
                pc_old <= pc;
                pc     <= pc + 32'd4;
            end
            if (ab_write) begin
                a_reg <= rd1;
                b_reg <= rd2;
            end
            if (alu_out_write) alu_out  <= alu_result;
            if (data_write)    data_reg <= mem_rdata;
        end
    end

`ifdef RETIRE_TRACE_EN
    always @(posedge clk) begin
        if (!reset && reg_write && rd != 5'd0)
            $display("retire pc=%08h instr=%08h x%0d <= %08h", pc_old, instr, rd, wb_data);
        if (!reset && mem_write)
            $display("retire pc=%08h instr=%08h M[%08h] <= %08h", pc_old, instr, alu_out, b_reg);
    end
`endif
endmodule

// File: tb/tb_rv32_mc_core.sv
// Random-program bench for rv32_mc_core against an instruction-level reference model.
module tb_rv32_mc_core;
    localparam int MW = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rv32_mc_core #(.MEM_WORDS(MW), .RESET_PC(32'h0)) dut (.clk(clk), .reset(reset));

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] rf   [32];
    logic [31:0] rmem [MW];
    logic [31:0] rpc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic f7b5, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] up, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {up, rd, op};
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        case (f3)
            3'd4:    return a ^ b;
            3'd6:    return a | b;
            3'd7:    return a & b;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    // ISA-level step: kind 0 = no architectural write, 1 = register rd, 2 = memory word idx.
    task automatic ref_step(input logic [31:0] w, output int cyc, output int kind, output int idx);
        logic [31:0] a, b, iimm, simm, uimm, res, ea;
        a    = rf[w[19:15]];
        b    = rf[w[24:20]];
        iimm = {{20{w[31]}}, w[31:20]};
        simm = {{20{w[31]}}, w[31:25], w[11:7]};
        uimm = {w[31:12], 12'h000};
        kind = 1; idx = int'(w[11:7]); cyc = 4; res = 32'd0;
        case (w[6:0])
            7'h37: res = uimm;
            7'h17: res = rpc + uimm;
            7'h13: res = alu_ref(w[14:12], a, iimm);
            7'h33: res = (w[14:12] == 3'd0 && w[30]) ? a - b : alu_ref(w[14:12], a, b);
            7'h03: begin ea = a + iimm; res = rmem[(ea >> 2) % MW]; cyc = 5; end
            7'h23: begin ea = a + simm; kind = 2; idx = int'((ea >> 2) % MW); rmem[idx] = b; end
            default: begin kind = 0; cyc = 2; end
        endcase
        if (kind == 1 && idx != 0) rf[idx] = res;
        rpc = rpc + 32'd4;
    endtask

    // Starts and ends on a negedge inside FETCH.
    task automatic run_one(input int k);
        logic [31:0] w, pc0;
        int cyc, kind, idx, n;
        pc0 = rpc;
        w   = rmem[(rpc >> 2) % MW];
        ref_step(w, cyc, kind, idx);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dut.control_fsm.current_state != dut.control_fsm.FETCH && n < 12);
        chk($sformatf("cycles[%0d]", k), n, cyc);
        chk($sformatf("pc[%0d]", k), dut.pc, rpc);
        chk($sformatf("pc_old[%0d]", k), dut.pc_old, pc0);
        if (kind == 1) chk($sformatf("x%0d[%0d]", idx, k), dut.RegFile.RFMem[idx], rf[idx]);
        if (kind == 2) chk($sformatf("M%0d[%0d]", idx, k), dut.memory.M[idx], rmem[idx]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    localparam int NPROG = 80;

    initial begin
        int cyc, kind, idx;
        logic [31:0] old_x4;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        for (int i = 0; i < MW; i++) rmem[i] = (i >= 128) ? $urandom : 32'd0;

        rmem[0]  = 32'h00014097;                               // auipc x1,0x14
        rmem[1]  = 32'h000c8117;                               // auipc x2,0xc8
        rmem[2]  = 32'h003ff197;                               // auipc x3,0x3ff
        rmem[3]  = enc_u(20'hABCDE, 5'd5, 7'h37);              // lui x5
        rmem[4]  = enc_i(12'hFFF, 5'd0, 3'd0, 5'd6, 7'h13);    // addi x6,x0,-1
        rmem[5]  = enc_s(12'h0A0, 5'd6, 5'd0);                 // sw x6,0xA0(x0)
        rmem[6]  = enc_i(12'h0A0, 5'd0, 3'd2, 5'd7, 7'h03);    // lw x7,0xA0(x0)
        rmem[7]  = enc_i(12'h005, 5'd0, 3'd0, 5'd0, 7'h13);    // addi x0,x0,5
        rmem[8]  = enc_i(12'd123, 5'd0, 3'd0, 5'd4, 7'h13);    // addi x4,x0,123
        rmem[9]  = enc_i(12'h7FD, 5'd0, 3'd2, 5'd1, 7'h03);    // lw wrapping past the end
        rmem[10] = enc_i(12'h0A3, 5'd0, 3'd2, 5'd2, 7'h03);    // lw misaligned
        for (int i = 11; i < NPROG; i++) begin
            logic [4:0] rd, r1, r2;
            logic [2:0] f3;
            int t;
            rd = 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: f3 = 3'd0; 1: f3 = 3'd4; 2: f3 = 3'd6; 3: f3 = 3'd7; default: f3 = 3'd2;
            endcase
            t = $urandom_range(0, 9);
            case (t)
                0:       rmem[i] = enc_u(20'($urandom), rd, 7'h37);
                1:       rmem[i] = enc_u(20'($urandom), rd, 7'h17);
                4, 5:    rmem[i] = enc_r(1'($urandom), r2, r1, f3, rd);
                6:       rmem[i] = enc_i(12'($urandom_range(12'h200, 12'h7FF)), 5'd0, 3'd2, rd, 7'h03);
                7:       rmem[i] = enc_s(12'($urandom_range(12'h200, 12'h3FF)), r2, 5'd0);
                8:       rmem[i] = 32'h0000000F;
                default: rmem[i] = enc_i(12'($urandom), r1, f3, rd, 7'h13);
            endcase
        end
        rmem[NPROG] = enc_i(12'h077, 5'd0, 3'd0, 5'd4, 7'h13); // aborted by reset
        for (int i = 0; i < MW; i++) dut.memory.M[i] = rmem[i];

        repeat (2) @(negedge clk);
        chk("rst_state", dut.control_fsm.current_state, dut.control_fsm.FETCH);
        chk("rst_pc", dut.pc, 32'h0);
        chk("rst_pc_old", dut.pc_old, 32'h0);
        chk("rst_instr", dut.instr, 32'h0);
        reset = 1'b0;

        rpc = 32'h0;
        ref_step(rmem[0], cyc, kind, idx);
        @(negedge clk);
        chk("dec_opcode", dut.opcode, 32'h17);
        chk("dec_imm", dut.instruction_decode.imm_ext, 32'h00014000);
        @(negedge clk);
        chk("auipc_a", dut.alu_input_a, 32'h0);
        chk("auipc_b", dut.alu_input_b, 32'h00014000);
        chk("auipc_ctl", dut.__tmp_ALUControl, 32'd0);
        chk("auipc_res", dut.alu_result, 32'h00014000);
        @(negedge clk);
        chk("aluwb_rd", dut.instruction_decode.rd, 32'd1);
        @(negedge clk);
        chk("fetch_state", dut.control_fsm.current_state, dut.control_fsm.FETCH);
        chk("x1", dut.RegFile.RFMem[1], 32'h00014000);

        for (int k = 1; k < NPROG; k++) begin
            run_one(k);
            if (k == 7) begin
                chk("x2_const", dut.RegFile.RFMem[2], 32'h000c8004);
                chk("x3_const", dut.RegFile.RFMem[3], 32'h003ff008);
                chk("x5_const", dut.RegFile.RFMem[5], 32'hABCDE000);
                chk("x6_const", dut.RegFile.RFMem[6], 32'hFFFFFFFF);
                chk("M40_const", dut.memory.M[40], 32'hFFFFFFFF);
                chk("x7_const", dut.RegFile.RFMem[7], 32'hFFFFFFFF);
                chk("x0_const", dut.RegFile.RFMem[0], 32'h0);
            end
        end

        // Reset while the addi sits in ALUWB: write-back must be lost.
        old_x4 = rf[4];
        repeat (3) @(negedge clk);
        chk("abort_rd", dut.instruction_decode.rd, 32'd4);
        reset = 1'b1;
        #1;
        chk("abort_state", dut.control_fsm.current_state, dut.control_fsm.FETCH);
        chk("abort_pc", dut.pc, 32'h0);
        repeat (2) @(negedge clk);
        chk("abort_x4", dut.RegFile.RFMem[4], old_x4);
        reset = 1'b0;

        rpc = 32'h0;
        for (int k = 0; k < 3; k++) run_one(100 + k);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
